// File: rtl/serial_parity_pkg.sv
// Shared FSM state encoding and parity-mode constants for the serial parity checker.
package serial_parity_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_BREAK  = 3'd4
    } state_t;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

    // Even: parity bit must equal the data XOR; odd: it must equal its complement.
    function automatic logic parity_mismatch(input logic acc, input logic par_bit, input int mode);
        return par_bit ^ acc ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/serial_parity_checker_parity_accum.sv
// Running XOR of serial data bits; clr restarts the accumulation for a new frame.
module parity_accum (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic par
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            par <= 1'b0;
        end else if (en) begin
            par <= par ^ bit_in;
        end
    end

endmodule

// File: rtl/serial_parity_checker.sv
// Serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Optional saturating error counter enabled by SERIAL_PARITY_ERR_CNT_EN.
module serial_parity_checker
    import serial_parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = PARITY_EVEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              x,
    input  logic              bit_en,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
`ifdef SERIAL_PARITY_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  data_sr_p0;
    logic               par_acc;
    logic               par_err_p0;
    logic               start_frame;
    logic               shift_en;
    logic               par_cap;
    logic               stop_cap;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        par_cap     = 1'b0;
        stop_cap    = 1'b0;
        if (bit_en) begin
            case (state)
                ST_IDLE: begin
                    if (!x) begin
                        state_nxt   = ST_DATA;
                        start_frame = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_en = 1'b1;
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        state_nxt = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_cap   = 1'b1;
                    state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    stop_cap  = 1'b1;
                    state_nxt = x ? ST_IDLE : ST_BREAK;
                end
                ST_BREAK: begin
                    if (x) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst || start_frame) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    parity_accum u_parity_accum (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_frame),
        .en     (shift_en),
        .bit_in (x),
        .par    (par_acc)
    );

    // Stage p0: assemble the word and resolve parity while the frame is in flight.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            for (int i = 0; i < DATA_W - 1; i++) begin
                data_sr_p0[i] <= data_sr_p0[i+1];
            end
            data_sr_p0[DATA_W-1] <= x;
        end
        if (par_cap) begin
            par_err_p0 <= parity_mismatch(par_acc, x, ODD_PARITY);
        end
    end

    // Stage p1: publish the completed frame one cycle after the stop bit is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= stop_cap;
            if (stop_cap) begin
                rx_data    <= data_sr_p0;
                parity_err <= par_err_p0;
                frame_err  <= ~x;
            end
        end
    end

`ifdef SERIAL_PARITY_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if (stop_cap && (par_err_p0 || !x) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Randomized self-checking bench: an even and an odd parity instance share stimulus
// and are compared every cycle against a frame-level reference model.
module tb_serial_parity_checker;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic x = 1'b1;
    logic bit_en = 1'b0;

    logic [DW-1:0] rx_data_e, rx_data_o;
    logic rx_valid_e, rx_valid_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;
`ifdef SERIAL_PARITY_ERR_CNT_EN
    logic [7:0] err_cnt_e, err_cnt_o;
`endif

    serial_parity_checker #(.DATA_W(DW), .ODD_PARITY(0)) dut_even (
        .clk(clk), .rst(rst), .x(x), .bit_en(bit_en),
        .rx_data(rx_data_e), .rx_valid(rx_valid_e), .parity_err(perr_e),
        .frame_err(ferr_e), .busy(busy_e)
`ifdef SERIAL_PARITY_ERR_CNT_EN
        , .err_cnt(err_cnt_e)
`endif
    );

    serial_parity_checker #(.DATA_W(DW), .ODD_PARITY(1)) dut_odd (
        .clk(clk), .rst(rst), .x(x), .bit_en(bit_en),
        .rx_data(rx_data_o), .rx_valid(rx_valid_o), .parity_err(perr_o),
        .frame_err(ferr_o), .busy(busy_o)
`ifdef SERIAL_PARITY_ERR_CNT_EN
        , .err_cnt(err_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit run = 1'b0;

    // Reference model: 0 = waiting for a start bit, 1 = collecting frame bits, 2 = line break.
    int       m_mode = 0;
    logic     m_bits[$];
    logic [DW-1:0] m_data = '0;
    logic     m_valid = 1'b0, m_perr_e = 1'b0, m_perr_o = 1'b0, m_ferr = 1'b0, m_busy = 1'b0;
    int       m_cnt_e = 0, m_cnt_o = 0;

    task automatic model_step(input logic xv, input logic en, input logic r);
        logic [DW-1:0] d;
        logic          xr;
        if (r) begin
            m_mode = 0; m_bits.delete();
            m_valid = 0; m_data = '0; m_perr_e = 0; m_perr_o = 0; m_ferr = 0; m_busy = 0;
            m_cnt_e = 0; m_cnt_o = 0;
            return;
        end
        m_valid = 1'b0;
        if (en) begin
            if (m_mode == 0) begin
                if (xv == 1'b0) begin
                    m_mode = 1;
                    m_bits.delete();
                end
            end else if (m_mode == 1) begin
                m_bits.push_back(xv);
                if (m_bits.size() == DW + 2) begin
                    d = '0;
                    for (int i = 0; i < DW; i++) d[i] = m_bits[i];
                    xr = ^d;
                    m_data   = d;
                    m_perr_e = (m_bits[DW] != xr);
                    m_perr_o = (m_bits[DW] != !xr);
                    m_ferr   = !m_bits[DW+1];
                    m_valid  = 1'b1;
                    if ((m_perr_e || m_ferr) && m_cnt_e < 255) m_cnt_e++;
                    if ((m_perr_o || m_ferr) && m_cnt_o < 255) m_cnt_o++;
                    m_mode = m_bits[DW+1] ? 0 : 2;
                end
            end else begin
                if (xv) m_mode = 0;
            end
        end
        m_busy = (m_mode != 0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 25)
                $display("FAIL %s at %0t: actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // One clock: inputs change on the falling edge, the model predicts the post-edge outputs.
    task automatic tick(input logic xv, input logic en, input logic r);
        @(negedge clk);
        x = xv; bit_en = en; rst = r;
        model_step(xv, en, r);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic pb, input logic sb, input int period);
        logic fb[$];
        fb.push_back(1'b0);
        for (int i = 0; i < DW; i++) fb.push_back(d[i]);
        fb.push_back(pb);
        fb.push_back(sb);
        foreach (fb[i]) begin
            for (int k = 0; k < period - 1; k++) tick(1'($urandom), 1'b0, 1'b0);
            tick(fb[i], 1'b1, 1'b0);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (run) begin
            chk("valid_e", 32'(rx_valid_e), 32'(m_valid));
            chk("valid_o", 32'(rx_valid_o), 32'(m_valid));
            chk("data_e", 32'(rx_data_e), 32'(m_data));
            chk("data_o", 32'(rx_data_o), 32'(m_data));
            chk("perr_e", 32'(perr_e), 32'(m_perr_e));
            chk("perr_o", 32'(perr_o), 32'(m_perr_o));
            chk("ferr_e", 32'(ferr_e), 32'(m_ferr));
            chk("ferr_o", 32'(ferr_o), 32'(m_ferr));
            chk("busy_e", 32'(busy_e), 32'(m_busy));
            chk("busy_o", 32'(busy_o), 32'(m_busy));
`ifdef SERIAL_PARITY_ERR_CNT_EN
            chk("errcnt_e", 32'(err_cnt_e), 32'(m_cnt_e));
            chk("errcnt_o", 32'(err_cnt_o), 32'(m_cnt_o));
`endif
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] d;
        logic pb, sb;
        int per, gap;

        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        run = 1'b1;
        chk("rst_valid", 32'(rx_valid_e), 32'd0);
        chk("rst_data", 32'(rx_data_e), 32'd0);
        chk("rst_busy", 32'(busy_e), 32'd0);
        chk("rst_perr", 32'(perr_e), 32'd0);
        chk("rst_ferr", 32'(ferr_e), 32'd0);
        repeat (3) tick(1'b1, 1'b1, 1'b0);

        // Good 0xA5 frame, even parity bit 0.
        send_frame(8'hA5, 1'b0, 1'b1, 1);
        chk("a5_valid", 32'(rx_valid_e), 32'd1);
        chk("a5_data", 32'(rx_data_e), 32'hA5);
        chk("a5_perr_even", 32'(perr_e), 32'd0);
        chk("a5_perr_odd", 32'(perr_o), 32'd1);
        chk("a5_ferr", 32'(ferr_e), 32'd0);
        tick(1'b1, 1'b1, 1'b0);
        chk("a5_pulse_end", 32'(rx_valid_e), 32'd0);
        chk("a5_hold", 32'(rx_data_e), 32'hA5);

        // Same frame, wrong parity.
        send_frame(8'hA5, 1'b1, 1'b1, 1);
        chk("a5bad_data", 32'(rx_data_e), 32'hA5);
        chk("a5bad_perr", 32'(perr_e), 32'd1);
        tick(1'b1, 1'b1, 1'b0);
        chk("a5bad_hold", 32'(perr_e), 32'd1);

        // Stop bit 0 followed by a held-low line.
        send_frame(8'hA5, 1'b0, 1'b0, 1);
        chk("brk_ferr", 32'(ferr_e), 32'd1);
        chk("brk_busy0", 32'(busy_e), 32'd1);
        repeat (5) tick(1'b0, 1'b1, 1'b0);
        chk("brk_busy5", 32'(busy_e), 32'd1);
        chk("brk_novalid", 32'(rx_valid_e), 32'd0);
        tick(1'b1, 1'b1, 1'b0);
        chk("brk_exit", 32'(busy_e), 32'd0);
        repeat (3) tick(1'b1, 1'b1, 1'b0);
        chk("brk_idle_valid", 32'(rx_valid_e), 32'd0);

        // Abort with reset after 3 data bits, then a clean 0x3C frame.
        tick(1'b0, 1'b1, 1'b0);
        repeat (3) tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        chk("abort_busy", 32'(busy_e), 32'd0);
        chk("abort_data", 32'(rx_data_e), 32'd0);
        tick(1'b1, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1, 1);
        chk("3c_valid", 32'(rx_valid_e), 32'd1);
        chk("3c_data", 32'(rx_data_e), 32'h3C);
        chk("3c_perr", 32'(perr_e), 32'd0);
        chk("3c_ferr", 32'(ferr_e), 32'd0);

        // Odd parity, slow bit strobe.
        send_frame(8'h00, 1'b1, 1'b1, 4);
        chk("odd_valid", 32'(rx_valid_o), 32'd1);
        chk("odd_data", 32'(rx_data_o), 32'h00);
        chk("odd_perr", 32'(perr_o), 32'd0);
        chk("odd_perr_even_dut", 32'(perr_e), 32'd1);
        tick(1'b1, 1'b0, 1'b0);
        chk("odd_pulse_width", 32'(rx_valid_o), 32'd0);

        // Back-to-back frames.
        send_frame(8'h5A, 1'b0, 1'b1, 1);
        send_frame(8'hC3, 1'b0, 1'b1, 1);
        chk("b2b_valid", 32'(rx_valid_e), 32'd1);
        chk("b2b_data", 32'(rx_data_e), 32'hC3);

        // Randomized traffic with errors, gaps, breaks and occasional aborts.
        for (int n = 0; n < 200; n++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick(1'b1, 1'($urandom), 1'b0);
            if ($urandom_range(0, 14) == 0) begin
                tick(1'b0, 1'b1, 1'b0);
                repeat ($urandom_range(0, 9)) tick(1'($urandom), 1'($urandom), 1'b0);
                tick(1'($urandom), 1'($urandom), 1'b1);
            end
            d   = DW'($urandom);
            pb  = (^d) ^ ($urandom_range(0, 3) == 0);
            sb  = ($urandom_range(0, 9) != 0);
            per = $urandom_range(1, 3);
            send_frame(d, pb, sb, per);
        end
        repeat (4) tick(1'b1, 1'b1, 1'b0);

`ifdef SERIAL_PARITY_ERR_CNT_EN
        tick(1'b1, 1'b1, 1'b1);
        chk("cnt_rst", 32'(err_cnt_e), 32'd0);
        for (int n = 0; n < 300; n++) begin
            d = DW'($urandom);
            send_frame(d, ~(^d), 1'b1, 1);
        end
        tick(1'b1, 1'b1, 1'b0);
        chk("cnt_sat_even", 32'(err_cnt_e), 32'd255);
        chk("cnt_odd_clean", 32'(err_cnt_o), 32'd0);
`endif

        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_parity_checker.md
SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

Interface
REQ-001 Parameter DATA_W SHALL be: default 8, meaning data bits per frame (range 1..32).
REQ-002 Parameter ODD_PARITY SHALL be: default 0, meaning 0 = even parity, 1 = odd parity.
REQ-003 Port clk SHALL be: input, 1 bit, the single clock; all logic samples on its rising edge.
REQ-004 Port rst SHALL be: input, 1 bit, reset, synchronous and active-high.
REQ-005 Port x SHALL be: input, 1 bit, serial line; idle level is 1.
REQ-006 Port bit_en SHALL be: input, 1 bit, bit strobe; x is sampled only in cycles with bit_en=1.
REQ-007 Port rx_data SHALL be: output, DATA_W bits, last received data word.
REQ-008 Port rx_valid SHALL be: output, 1 bit, one-cycle pulse marking frame completion.
REQ-009 Port parity_err SHALL be: output, 1 bit, parity mismatch for the frame flagged by rx_valid.
REQ-010 Port frame_err SHALL be: output, 1 bit, stop bit sampled as 0 for the frame flagged by rx_valid.
REQ-011 Port busy SHALL be: output, 1 bit, 1 whenever the state is not IDLE.

Function
REQ-012 Frame format SHALL be: start bit (0), DATA_W data bits LSB first, one parity bit, stop bit (1).
REQ-013 FSM states SHALL be: IDLE, DATA, PARITY, STOP, BREAK; the state changes only on bit_en=1 cycles, except for reset.
REQ-014 IDLE SHALL go to DATA on a sampled x=0; on x=1 it stays in IDLE.
REQ-015 DATA SHALL shift sampled bits into the word LSB-first and XOR each one into a running parity; after the DATA_W-th bit it goes to PARITY.
REQ-016 Even mode SHALL require parity bit = XOR of data bits; odd mode SHALL require parity bit = ~XOR of data bits.
REQ-017 PARITY SHALL compute the mismatch and go to STOP.
REQ-018 STOP SHALL, in the cycle after the stop bit is sampled, pulse rx_valid for exactly 1 cycle and update rx_data, parity_err and frame_err together.
REQ-019 STOP exit SHALL be: stop bit = 1 -> IDLE; stop bit = 0 -> frame_err=1 and BREAK.
REQ-020 BREAK SHALL stay put until a sampled x=1, then go to IDLE; it never starts a frame directly.
REQ-021 rx_data, parity_err and frame_err SHALL hold their values until the next rx_valid.
REQ-022 Cycles with bit_en=0 SHALL freeze the state, bit counter and parity accumulator; rx_valid stays 0 in those cycles.
REQ-023 Back-to-back frames SHALL be supported: a start bit sampled in the first bit_en cycle after STOP is accepted.
REQ-024 Bit counter width SHALL be $clog2(DATA_W+1); the counter clears on entry to DATA.

Reset
REQ-025 rst=1 SHALL, at the next clk edge, force state IDLE, counter 0, parity accumulator 0, rx_data 0, rx_valid 0, parity_err 0, frame_err 0 and busy 0.
REQ-026 Reset mid-frame SHALL abort the frame with no rx_valid; rst takes priority over bit_en.

Configuration
REQ-027 Macro SERIAL_PARITY_ERR_CNT_EN, when defined, SHALL add output err_cnt[7:0] that increments once per rx_valid carrying parity_err or frame_err.
REQ-028 err_cnt SHALL saturate at 255 and clear on rst.
REQ-029 When SERIAL_PARITY_ERR_CNT_EN is undefined, the err_cnt port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package serial_parity_pkg SHALL hold the FSM state enum and the constants PARITY_EVEN=0 and PARITY_ODD=1, shared with the parity generator.
REQ-031 Sub-module parity_accum SHALL be used: clear/enable/bit inputs, running XOR output.

Verification (DATA_W=8, bit_en=1 every cycle unless stated)
REQ-032 Even mode, x = 0, 1,0,1,0,0,1,0,1 (0xA5), parity 0, stop 1 -> single rx_valid pulse, rx_data=0xA5, parity_err=0, frame_err=0.
REQ-033 Same frame with parity 1 -> rx_valid, rx_data=0xA5, parity_err=1.
REQ-034 0xA5 frame with stop 0 and x held 0 for 5 bits -> frame_err=1, busy=1 until the first x=1, then IDLE with no spurious frame.
REQ-035 rst after 3 data bits, then a full 0x3C frame -> no rx_valid for the aborted frame; rx_data=0x3C, no errors.
REQ-036 ODD_PARITY=1, 0x00 with parity 1 sent with bit_en 1-of-4 cycles -> rx_valid is 1 cycle wide, rx_data=0x00, parity_err=0.
REQ-037 With SERIAL_PARITY_ERR_CNT_EN, 300 bad-parity frames -> err_cnt=255.
